// File: rtl/sync_bidir_fifo_pkg.sv
// rtl/sync_bidir_fifo_pkg.sv - direction-ownership state and direction encodings
package sync_bidir_fifo_pkg;

  typedef enum logic [1:0] {
    A2B   = 2'd0,
    B2A   = 2'd1,
    DRAIN = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

endpackage

// File: rtl/sync_bidir_fifo_mem.sv
// rtl/sync_bidir_fifo_mem.sv - single-clock simple dual-port RAM, fall-through or registered read
module sync_bidir_fifo_mem #(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 4,
  parameter     FALLTHROUGH = "TRUE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem_q [0:(1<<ASIZE)-1];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (FALLTHROUGH == "TRUE") begin : g_fwft
    logic unused_rd_ctl;
    assign unused_rd_ctl = re ^ rst_n;
    assign rdata = mem_q[raddr];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] rdata_d;

    // Word is held until the next accepted read.
    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_bidir_fifo.sv
// rtl/sync_bidir_fifo.sv - shared-buffer bidirectional FIFO with drain-then-turnaround ownership; SYNC_BIDIR_FIFO_ERR_EN enables sticky err
module sync_bidir_fifo #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter     FALLTHROUGH   = "TRUE",
  parameter int AFULL_MARGIN  = 1,
  parameter int AEMPTY_MARGIN = 1,
  parameter bit INIT_DIR      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_winc,
  input  logic [DSIZE-1:0] a_wdata,
  input  logic             a_rinc,
  output logic [DSIZE-1:0] a_rdata,
  output logic             a_full,
  output logic             a_afull,
  output logic             a_empty,
  output logic             a_aempty,
  input  logic             b_winc,
  input  logic [DSIZE-1:0] b_wdata,
  input  logic             b_rinc,
  output logic [DSIZE-1:0] b_rdata,
  output logic             b_full,
  output logic             b_afull,
  output logic             b_empty,
  output logic             b_aempty,
  input  logic             a_dir_req,
  input  logic             b_dir_req,
  output logic             dir,
  output logic             turn,
  output logic [ASIZE:0]   level,
  input  logic             err_clr,
  output logic             err
);
  import sync_bidir_fifo_pkg::*;

  localparam int DEPTH_I     = 1 << ASIZE;
  localparam int AFULL_TH_I  = (AFULL_MARGIN >= DEPTH_I) ? 0 : DEPTH_I - AFULL_MARGIN;
  localparam int AEMPTY_TH_I = (AEMPTY_MARGIN > DEPTH_I) ? DEPTH_I : AEMPTY_MARGIN;
  localparam logic [ASIZE:0] DEPTH_L   = DEPTH_I[ASIZE:0];
  localparam logic [ASIZE:0] AFULL_TH  = AFULL_TH_I[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_TH = AEMPTY_TH_I[ASIZE:0];

  state_t         state_q, state_d;
  logic           dir_q, dir_d;
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] level_q, level_d;
  logic           err_q, err_d;

  logic           w_lock, wr_full, wr_afull, rd_empty, rd_aempty;
  logic           w_inc, r_inc, wr_en, rd_en;
  logic [DSIZE-1:0] w_data, r_data;

  // Flags come only from registered level/state, never from the inc inputs.
  always_comb begin
    w_lock    = (state_q == DRAIN) || (state_q == TURN);
    wr_full   = w_lock || (level_q == DEPTH_L);
    wr_afull  = w_lock || (level_q >= AFULL_TH);
    rd_empty  = (state_q == TURN) || (level_q == '0);
    rd_aempty = (state_q == TURN) || (level_q <= AEMPTY_TH);
    a_full    = (dir_q == DIR_A2B) ? wr_full   : 1'b1;
    a_afull   = (dir_q == DIR_A2B) ? wr_afull  : 1'b1;
    b_full    = (dir_q == DIR_B2A) ? wr_full   : 1'b1;
    b_afull   = (dir_q == DIR_B2A) ? wr_afull  : 1'b1;
    a_empty   = (dir_q == DIR_B2A) ? rd_empty  : 1'b1;
    a_aempty  = (dir_q == DIR_B2A) ? rd_aempty : 1'b1;
    b_empty   = (dir_q == DIR_A2B) ? rd_empty  : 1'b1;
    b_aempty  = (dir_q == DIR_A2B) ? rd_aempty : 1'b1;
  end

  always_comb begin
    w_inc   = (dir_q == DIR_A2B) ? a_winc  : b_winc;
    w_data  = (dir_q == DIR_A2B) ? a_wdata : b_wdata;
    r_inc   = (dir_q == DIR_A2B) ? b_rinc  : a_rinc;
    wr_en   = w_inc && !wr_full;
    rd_en   = r_inc && !rd_empty;
    wptr_d  = wptr_q + {{ASIZE{1'b0}}, wr_en};
    rptr_d  = rptr_q + {{ASIZE{1'b0}}, rd_en};
    level_d = level_q + {{ASIZE{1'b0}}, wr_en} - {{ASIZE{1'b0}}, rd_en};
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      A2B:     if (b_dir_req && !a_dir_req) state_d = DRAIN;
      B2A:     if (a_dir_req && !b_dir_req) state_d = DRAIN;
      DRAIN:   if (level_q == '0) state_d = TURN;
      default: begin
        dir_d   = ~dir_q;
        state_d = (dir_q == DIR_A2B) ? B2A : A2B;
      end
    endcase
  end

`ifdef SYNC_BIDIR_FIFO_ERR_EN
  logic err_set;
  always_comb begin
    err_set = (a_winc && a_full) || (b_winc && b_full) ||
              (a_rinc && a_empty) || (b_rinc && b_empty);
    err_d   = err_set || (err_q && !err_clr);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  always_comb err_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_DIR ? A2B : B2A;
      dir_q   <= INIT_DIR;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  sync_bidir_fifo_mem #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH(FALLTHROUGH)
  ) u_mem (
    .clk(clk), .rst_n(rst_n),
    .we(wr_en), .waddr(wptr_q[ASIZE-1:0]), .wdata(w_data),
    .re(rd_en), .raddr(rptr_q[ASIZE-1:0]), .rdata(r_data)
  );

  assign a_rdata = r_data;
  assign b_rdata = r_data;
  assign dir     = dir_q;
  assign turn    = (state_q == DRAIN) || (state_q == TURN);
  assign level   = level_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sync_bidir_fifo.sv
// tb/tb_sync_bidir_fifo.sv - directed bench: fall-through and registered-read instances on shared stimulus
module tb_sync_bidir_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_winc, a_rinc, b_winc, b_rinc, a_dir_req, b_dir_req, err_clr;
  logic [7:0] a_wdata, b_wdata;

  logic [7:0] a_rdata, b_rdata, ra_rdata, rb_rdata;
  logic       a_full, a_afull, a_empty, a_aempty, b_full, b_afull, b_empty, b_aempty;
  logic       ra_full, ra_afull, ra_empty, ra_aempty, rb_full, rb_afull, rb_empty, rb_aempty;
  logic       dir, turn, err, r_dir, r_turn, r_err;
  logic [4:0] level, r_level;

  int checks = 0;
  int failures = 0;
  logic exp_err;

  always #5 clk = ~clk;

  sync_bidir_fifo #(.FALLTHROUGH("TRUE")) dut (
    .clk(clk), .rst_n(rst_n),
    .a_winc(a_winc), .a_wdata(a_wdata), .a_rinc(a_rinc), .a_rdata(a_rdata),
    .a_full(a_full), .a_afull(a_afull), .a_empty(a_empty), .a_aempty(a_aempty),
    .b_winc(b_winc), .b_wdata(b_wdata), .b_rinc(b_rinc), .b_rdata(b_rdata),
    .b_full(b_full), .b_afull(b_afull), .b_empty(b_empty), .b_aempty(b_aempty),
    .a_dir_req(a_dir_req), .b_dir_req(b_dir_req), .dir(dir), .turn(turn),
    .level(level), .err_clr(err_clr), .err(err)
  );

  sync_bidir_fifo #(.FALLTHROUGH("FALSE")) dut_reg (
    .clk(clk), .rst_n(rst_n),
    .a_winc(a_winc), .a_wdata(a_wdata), .a_rinc(a_rinc), .a_rdata(ra_rdata),
    .a_full(ra_full), .a_afull(ra_afull), .a_empty(ra_empty), .a_aempty(ra_aempty),
    .b_winc(b_winc), .b_wdata(b_wdata), .b_rinc(b_rinc), .b_rdata(rb_rdata),
    .b_full(rb_full), .b_afull(rb_afull), .b_empty(rb_empty), .b_aempty(rb_aempty),
    .a_dir_req(a_dir_req), .b_dir_req(b_dir_req), .dir(r_dir), .turn(r_turn),
    .level(r_level), .err_clr(err_clr), .err(r_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SYNC_BIDIR_FIFO_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    {a_winc, a_rinc, b_winc, b_rinc, a_dir_req, b_dir_req, err_clr} = '0;
    a_wdata = '0;
    b_wdata = '0;
    tick(); tick();

    chk("rst_a_full", a_full, 0);
    chk("rst_a_afull", a_afull, 0);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_b_full", b_full, 1);
    chk("rst_b_empty", b_empty, 1);
    chk("rst_b_aempty", b_aempty, 1);
    chk("rst_level", level, 0);
    chk("rst_dir", dir, 1);
    chk("rst_turn", turn, 0);
    chk("rst_err", err, 0);
    chk("rst_reg_rdata", rb_rdata, 0);

    rst_n = 1'b1;
    tick();

    a_winc = 1'b1; a_wdata = 8'h11; tick(); a_winc = 1'b0;
    chk("w1_level", level, 1);
    chk("w1_fwft_rdata", b_rdata, 8'h11);
    chk("w1_b_empty", b_empty, 0);
    chk("w1_b_aempty", b_aempty, 1);
    b_rinc = 1'b1; tick(); b_rinc = 1'b0;
    chk("r1_reg_rdata", rb_rdata, 8'h11);
    chk("r1_level", level, 0);

    a_winc = 1'b1; a_wdata = 8'hAB; tick(); a_winc = 1'b0;
    chk("wab_reg_hold", rb_rdata, 8'h11);
    chk("wab_fwft", b_rdata, 8'hAB);
    b_rinc = 1'b1; tick(); b_rinc = 1'b0;
    chk("rab_reg_rdata", rb_rdata, 8'hAB);

    for (int i = 0; i < 16; i++) begin
      a_winc = 1'b1; a_wdata = 8'h30 + 8'(i); tick();
      if (i == 13) chk("fill14_afull", a_afull, 0);
      if (i == 14) begin
        chk("fill15_afull", a_afull, 1);
        chk("fill15_full", a_full, 0);
      end
    end
    chk("fill16_full", a_full, 1);
    chk("fill16_level", level, 16);
    a_wdata = 8'hEE; tick(); a_winc = 1'b0;
    chk("fill17_level", level, 16);
    chk("fill17_err", err, 32'(exp_err));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("fill_errclr", err, 0);

    for (int i = 0; i < 16; i++) begin
      chk("drain16_data", b_rdata, 8'h30 + 8'(i));
      b_rinc = 1'b1; tick();
    end
    b_rinc = 1'b0;
    chk("drain16_empty", b_empty, 1);
    chk("drain16_level", level, 0);
    chk("drain16_reg_last", rb_rdata, 8'h3F);

    for (int i = 0; i < 3; i++) begin
      a_winc = 1'b1; a_wdata = 8'h50 + 8'(i); tick();
    end
    for (int i = 0; i < 40; i++) begin
      a_wdata = 8'h53 + 8'(i); b_rinc = 1'b1;
      chk("wrap_data", b_rdata, 8'h50 + 8'(i));
      tick();
      chk("wrap_level", level, 3);
    end
    b_rinc = 1'b0;
    a_wdata = 8'h7B; tick();
    a_wdata = 8'h7C; tick(); a_winc = 1'b0;
    chk("pre_turn_level", level, 5);

    b_dir_req = 1'b1; tick();
    chk("drain_turn", turn, 1);
    chk("drain_a_full", a_full, 1);
    chk("drain_a_afull", a_afull, 1);
    chk("drain_dir", dir, 1);
    for (int i = 0; i < 5; i++) begin
      chk("drain_data", b_rdata, 8'h78 + 8'(i));
      b_rinc = 1'b1; tick();
    end
    b_rinc = 1'b0;
    chk("drain_done_turn", turn, 1);
    chk("drain_done_level", level, 0);
    tick();
    chk("turn_turn", turn, 1);
    chk("turn_a_full", a_full, 1);
    chk("turn_b_full", b_full, 1);
    chk("turn_a_empty", a_empty, 1);
    chk("turn_b_empty", b_empty, 1);
    chk("turn_dir", dir, 1);
    tick();
    chk("b2a_turn", turn, 0);
    chk("b2a_dir", dir, 0);
    chk("b2a_b_full", b_full, 0);
    chk("b2a_a_full", a_full, 1);
    chk("b2a_a_empty", a_empty, 1);
    b_winc = 1'b1; b_wdata = 8'h22; tick(); b_winc = 1'b0;
    chk("b2a_a_rdata", a_rdata, 8'h22);
    chk("b2a_level", level, 1);
    a_rinc = 1'b1; tick(); a_rinc = 1'b0;
    chk("b2a_reg_a_rdata", ra_rdata, 8'h22);
    chk("b2a_read_level", level, 0);

    b_winc = 1'b1; b_wdata = 8'h01; tick();
    b_wdata = 8'h02; tick(); b_winc = 1'b0;
    chk("midfill_level", level, 2);
    b_dir_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_dir", dir, 1);
    chk("arst_turn", turn, 0);
    chk("arst_a_full", a_full, 0);
    chk("arst_b_full", b_full, 1);
    chk("arst_b_empty", b_empty, 1);
    chk("arst_reg_rdata", rb_rdata, 0);
    chk("arst_err", err, 0);
    tick(); rst_n = 1'b1; tick();

    b_dir_req = 1'b1; tick();
    chk("lat_drain_turn", turn, 1);
    tick();
    chk("lat_turn_b_full", b_full, 1);
    chk("lat_turn_dir", dir, 1);
    tick();
    chk("lat_new_dir", dir, 0);
    chk("lat_b_full", b_full, 0);
    b_winc = 1'b1; b_wdata = 8'h33; tick(); b_winc = 1'b0;
    chk("lat_level", level, 1);
    chk("lat_a_rdata", a_rdata, 8'h33);

    b_rinc = 1'b1; tick(); b_rinc = 1'b0;
    chk("err_set", err, 32'(exp_err));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clear", err, 0);
    b_rinc = 1'b1; err_clr = 1'b1; tick(); b_rinc = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", err, 32'(exp_err));
    chk("err_level_kept", level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
